change_dispenser: RTL and testbench

- Sequential stage directly downstream of the change machine.
- Accepts its coin selection (first_coin, second_coin, encoded in nickels) on a start strobe.
- Drives the coin-hopper eject solenoids one coin at a time with fixed pulse and gap timing.
- Owns the coin inventory counters, which feed back into the change machine's quarters/dimes/nickels inputs.

---
 rtl/change_dispenser_if.sv | 31 +++
 rtl/change_dispenser.sv | 215 +++++++++++++++++++++
 tb/tb_change_dispenser.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Coin-pair request, restock and hopper/status signals between the dispenser and its driver.
// The master drives the request and restock side; the slave (dispenser) drives status and ejects.
interface change_dispenser_if;
    logic       start;
    logic [2:0] first_coin;
    logic [2:0] second_coin;
    logic       load;
    logic [1:0] load_quarters;
    logic [1:0] load_dimes;
    logic [1:0] load_nickels;
    logic [1:0] quarters;
    logic [1:0] dimes;
    logic [1:0] nickels;
    logic       eject_q;
    logic       eject_d;
    logic       eject_n;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] dispensed;

    modport master (
        output start, first_coin, second_coin, load, load_quarters, load_dimes, load_nickels,
        input  quarters, dimes, nickels, eject_q, eject_d, eject_n, busy, done, error, dispensed
    );

    modport slave (
        input  start, first_coin, second_coin, load, load_quarters, load_dimes, load_nickels,
        output quarters, dimes, nickels, eject_q, eject_d, eject_n, busy, done, error, dispensed
    );
endinterface

// File: rtl/change_dispenser.sv
// Dispenses a two-coin selection one coin at a time through the hopper solenoids
// and owns the coin inventory counters.
module change_dispenser #(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    change_dispenser_if.slave   bus
);

    localparam int unsigned INV_W   = 2;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned DISP_W  = 4;
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    localparam logic [CODE_W-1:0] C_NONE    = CODE_W'(0);
    localparam logic [CODE_W-1:0] C_NICKEL  = CODE_W'(1);
    localparam logic [CODE_W-1:0] C_DIME    = CODE_W'(2);
    localparam logic [CODE_W-1:0] C_QUARTER = CODE_W'(5);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EJECT1 = 3'd1,
        GAP1   = 3'd2,
        EJECT2 = 3'd3,
        GAP2   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [INV_W-1:0]    r_q,       w_q_nxt;
    logic [INV_W-1:0]    r_d,       w_d_nxt;
    logic [INV_W-1:0]    r_n,       w_n_nxt;
    logic [CODE_W-1:0]   r_cur,     w_cur_nxt;
    logic [CODE_W-1:0]   r_coin2,   w_coin2_nxt;
    logic                r_err,     w_err_nxt;
    logic [DISP_W-1:0]   r_disp,    w_disp_nxt;
    logic                r_eject_q, w_eject_q_nxt;
    logic                r_eject_d, w_eject_d_nxt;
    logic                r_eject_n, w_eject_n_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                w_take;
    logic [CODE_W-1:0]   w_take_code;
    logic                w_eject_active;

    // Coin can be ejected: known denomination with stock on hand.
    function automatic logic f_avail(input logic [CODE_W-1:0] code,
                                     input logic [INV_W-1:0] q,
                                     input logic [INV_W-1:0] d,
                                     input logic [INV_W-1:0] n);
        case (code)
            C_NICKEL:  f_avail = (n != '0);
            C_DIME:    f_avail = (d != '0);
            C_QUARTER: f_avail = (q != '0);
            default:   f_avail = 1'b0;
        endcase
    endfunction

    // Coin request is faulty: unknown code or denomination out of stock; "none" is not a fault.
    function automatic logic f_err(input logic [CODE_W-1:0] code,
                                   input logic [INV_W-1:0] q,
                                   input logic [INV_W-1:0] d,
                                   input logic [INV_W-1:0] n);
        case (code)
            C_NONE:    f_err = 1'b0;
            C_NICKEL:  f_err = (n == '0);
            C_DIME:    f_err = (d == '0);
            C_QUARTER: f_err = (q == '0);
            default:   f_err = 1'b1;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_n_nxt     = r_n;
        w_cur_nxt   = r_cur;
        w_coin2_nxt = r_coin2;
        w_err_nxt   = r_err;
        w_disp_nxt  = r_disp;
        w_take      = 1'b0;
        w_take_code = C_NONE;

        case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_q_nxt = bus.load_quarters;
                    w_d_nxt = bus.load_dimes;
                    w_n_nxt = bus.load_nickels;
                end else if (bus.start) begin
                    w_coin2_nxt = bus.second_coin;
                    w_disp_nxt  = '0;
                    w_err_nxt   = f_err(bus.first_coin, r_q, r_d, r_n);
                    if (f_avail(bus.first_coin, r_q, r_d, r_n)) begin
                        w_state_nxt = EJECT1;
                        w_take      = 1'b1;
                        w_take_code = bus.first_coin;
                    end else begin
                        // Skipped first coin: second coin is evaluated in the same cycle.
                        w_err_nxt = w_err_nxt | f_err(bus.second_coin, r_q, r_d, r_n);
                        if (f_avail(bus.second_coin, r_q, r_d, r_n)) begin
                            w_state_nxt = EJECT2;
                            w_take      = 1'b1;
                            w_take_code = bus.second_coin;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end
            end
            EJECT1: begin
                if (r_cnt == HOLD_LAST) w_state_nxt = GAP1;
                else                    w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            GAP1: begin
                if (r_cnt == GAP_LAST) begin
                    if (f_avail(r_coin2, r_q, r_d, r_n)) begin
                        w_state_nxt = EJECT2;
                        w_take      = 1'b1;
                        w_take_code = r_coin2;
                    end else begin
                        w_err_nxt   = r_err | f_err(r_coin2, r_q, r_d, r_n);
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            EJECT2: begin
                if (r_cnt == HOLD_LAST) w_state_nxt = GAP2;
                else                    w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            GAP2: begin
                if (r_cnt == GAP_LAST) w_state_nxt = DONE;
                else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Entering an eject state consumes one coin from inventory.
        if (w_take) begin
            w_cur_nxt  = w_take_code;
            w_disp_nxt = w_disp_nxt + DISP_W'(w_take_code);
            case (w_take_code)
                C_QUARTER: w_q_nxt = r_q - INV_W'(1);
                C_DIME:    w_d_nxt = r_d - INV_W'(1);
                C_NICKEL:  w_n_nxt = r_n - INV_W'(1);
                default:   w_q_nxt = r_q;
            endcase
        end

        w_eject_active = (w_state_nxt == EJECT1) || (w_state_nxt == EJECT2);
        w_eject_q_nxt  = w_eject_active && (w_cur_nxt == C_QUARTER);
        w_eject_d_nxt  = w_eject_active && (w_cur_nxt == C_DIME);
        w_eject_n_nxt  = w_eject_active && (w_cur_nxt == C_NICKEL);
        w_busy_nxt     = w_eject_active || (w_state_nxt == GAP1) || (w_state_nxt == GAP2);
        w_done_nxt     = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_n       <= '0;
            r_cur     <= C_NONE;
            r_coin2   <= C_NONE;
            r_err     <= 1'b0;
            r_disp    <= '0;
            r_eject_q <= 1'b0;
            r_eject_d <= 1'b0;
            r_eject_n <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_q       <= w_q_nxt;
            r_d       <= w_d_nxt;
            r_n       <= w_n_nxt;
            r_cur     <= w_cur_nxt;
            r_coin2   <= w_coin2_nxt;
            r_err     <= w_err_nxt;
            r_disp    <= w_disp_nxt;
            r_eject_q <= w_eject_q_nxt;
            r_eject_d <= w_eject_d_nxt;
            r_eject_n <= w_eject_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.quarters  = r_q;
    assign bus.dimes     = r_d;
    assign bus.nickels   = r_n;
    assign bus.eject_q   = r_eject_q;
    assign bus.eject_d   = r_eject_d;
    assign bus.eject_n   = r_eject_n;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_err;
    assign bus.dispensed = r_disp;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table with per-cycle eject timeline checks and a
// done-time scoreboard, plus hand sequences for ignored requests and mid-transaction reset.
module tb_change_dispenser;

    localparam int unsigned HOLD = 3;
    localparam int unsigned GAP  = 2;

    typedef struct {
        int lq, ld, ln;        // restock values
        int c1, c2;            // requested coin codes
        int e1, e2;            // coin codes actually ejected, in order (0 = none)
        int eq, ed, en;        // inventory after the transaction
        int edisp, eerr;
    } vec_t;

    typedef struct {
        int q, d, n, disp, err, done_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[8];

    change_dispenser_if bus();

    change_dispenser #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected coin on the solenoids in cycle k after start (k=1 is the first cycle).
    function automatic int exp_code(input int e1, input int e2, input int k);
        int t = 1;
        exp_code = 0;
        if (e1 != 0) begin
            if (k >= t && k < t + int'(HOLD)) exp_code = e1;
            t += int'(HOLD + GAP);
        end
        if (e2 != 0) begin
            if (k >= t && k < t + int'(HOLD)) exp_code = e2;
        end
    endfunction

    function automatic int exp_done(input int e1, input int e2);
        exp_done = 1 + ((e1 != 0) ? int'(HOLD + GAP) : 0) + ((e2 != 0) ? int'(HOLD + GAP) : 0);
    endfunction

    function automatic int all_outs();
        all_outs = int'({bus.eject_q, bus.eject_d, bus.eject_n, bus.busy, bus.done, bus.error,
                         bus.dispensed, bus.quarters, bus.dimes, bus.nickels});
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("quarters", int'(bus.quarters), e.q);
                chk("dimes", int'(bus.dimes), e.d);
                chk("nickels", int'(bus.nickels), e.n);
                chk("dispensed", int'(bus.dispensed), e.disp);
                chk("error", int'(bus.error), e.err);
            end
        end
    end

    task automatic do_load(input int lq, input int ld, input int ln);
        @(posedge clk); #1;
        bus.load = 1'b1;
        bus.load_quarters = 2'(lq);
        bus.load_dimes    = 2'(ld);
        bus.load_nickels  = 2'(ln);
        @(posedge clk); #1;
        bus.load = 1'b0;
        @(negedge clk);
        chk("load_inventory", int'({bus.quarters, bus.dimes, bus.nickels}),
            int'({2'(lq), 2'(ld), 2'(ln)}));
    endtask

    task automatic run_vec(input vec_t v, input bit disturb);
        int   dk;
        int   s;
        int   code;
        exp_t e;
        do_load(v.lq, v.ld, v.ln);
        dk = exp_done(v.e1, v.e2);
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.first_coin  = 3'(v.c1);
        bus.second_coin = 3'(v.c2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        s = cyc;
        e = '{q: v.eq, d: v.ed, n: v.en, disp: v.edisp, err: v.eerr, done_cyc: s + dk - 1};
        sb.push_back(e);
        for (int k = 1; k <= dk; k++) begin
            @(negedge clk);
            code = exp_code(v.e1, v.e2, k);
            chk($sformatf("busy_ejects c%0d", k),
                int'({bus.busy, bus.eject_q, bus.eject_d, bus.eject_n}),
                int'({k < dk, code == 5, code == 2, code == 1}));
            if (disturb && k == 1) begin
                bus.start = 1'b1; bus.first_coin = 3'd1; bus.second_coin = 3'd1;
                bus.load  = 1'b1; bus.load_quarters = 2'd0; bus.load_dimes = 2'd0;
                bus.load_nickels = 2'd0;
            end
            if (disturb && k == 2) begin
                bus.start = 1'b0;
                bus.load  = 1'b0;
            end
        end
        for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk("error_hold", int'(bus.error), v.eerr);
        chk("dispensed_hold", int'(bus.dispensed), v.edisp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vec_t rv;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.first_coin = '0; bus.second_coin = '0;
        bus.load  = 1'b0; bus.load_quarters = '0; bus.load_dimes = '0; bus.load_nickels = '0;

        //          lq ld ln  c1 c2  e1 e2  eq ed en  disp err
        vecs[0] = '{2, 1, 3,  2, 1,  2, 1,  2, 0, 2,  3,   0};
        vecs[1] = '{2, 1, 3,  0, 0,  0, 0,  2, 1, 3,  0,   0};
        vecs[2] = '{0, 1, 0,  2, 2,  2, 0,  0, 0, 0,  2,   1};
        vecs[3] = '{1, 0, 0,  3, 5,  5, 0,  0, 0, 0,  5,   1};
        vecs[4] = '{3, 3, 3,  5, 5,  5, 5,  1, 3, 3,  10,  0};
        vecs[5] = '{0, 0, 0,  1, 7,  0, 0,  0, 0, 0,  0,   1};
        vecs[6] = '{0, 0, 1,  0, 1,  1, 0,  0, 0, 0,  1,   0};
        vecs[7] = '{1, 2, 3,  4, 6,  0, 0,  1, 2, 3,  0,   1};

        #3;
        chk("reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

        // start and load pulsed during EJECT1 must be ignored
        rv = '{3, 3, 3,  5, 0,  5, 0,  2, 3, 3,  5, 0};
        run_vec(rv, 1'b1);

        // Reset in the middle of the second eject pulse
        do_load(1, 1, 1);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.first_coin = 3'd2; bus.second_coin = 3'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_eject2_state", int'({bus.busy, bus.eject_q, bus.eject_d, bus.eject_n,
                                      bus.quarters, bus.dimes, bus.nickels}),
            int'({4'b1001, 2'd1, 2'd0, 2'd0}));
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", all_outs(), 0);

        rv = '{2, 2, 2,  5, 1,  5, 1,  1, 2, 1,  6, 0};
        run_vec(rv, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
